// File: rtl/m_mem_ctrl.sv
// M-stage data-memory access controller: byte-lane steering, req/ack handshake
// with a variable-latency memory, pipeline stall, timeout and misalignment detect.
module m_mem_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        m_data_req,
  output logic [31:0] m_data_addr,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_wdata,
  input  logic        m_data_ack,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        bus_err,
  output logic        adel,
  output logic        ades
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_store;
  logic             mis;
  logic             issue;

  function automatic logic [3:0] lane_byteen(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    case (size)
      2'b00:   lane_byteen = 4'b0001 << addr_lo;
      2'b01:   lane_byteen = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: lane_byteen = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                             input logic [31:0] wdata);
    case (size)
      2'b00:   lane_wdata = {4{wdata[7:0]}};
      2'b01:   lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase
  endfunction

  // Size 2'b11 behaves as a word access.
  assign mis = req_valid &
               ((req_size[1] & (req_addr[1:0] != 2'b00)) |
                ((req_size == 2'b01) & req_addr[0]));

  assign adel  = mis & ~req_we;
  assign ades  = mis & req_we;
  assign issue = req_valid & ~mis;

  // DONE never stalls, so the pipeline moves past the completed instruction there.
  assign stall = (state == IDLE) ? issue : (state == REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      is_store      <= 1'b0;
      m_data_req    <= 1'b0;
      m_data_addr   <= '0;
      m_data_byteen <= '0;
      m_data_wdata  <= '0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            m_data_addr   <= {req_addr[31:2], 2'b00};
            m_data_byteen <= req_we ? lane_byteen(req_size, req_addr[1:0]) : 4'b0000;
            m_data_wdata  <= lane_wdata(req_size, req_wdata);
            is_store      <= req_we;
            cnt           <= '0;
            m_data_req    <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          // An ack on the final allowed cycle still completes normally.
          if (m_data_ack) begin
            if (!is_store) rd_data <= m_data_rdata;
            rd_valid   <= 1'b1;
            m_data_req <= 1'b0;
            state      <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rd_data    <= '0;
            rd_valid   <= 1'b1;
            bus_err    <= 1'b1;
            m_data_req <= 1'b0;
            state      <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Bench for m_mem_ctrl: directed and randomized accesses against a
// transaction-level reference model of lane steering, latency and timeout.
module tb_m_mem_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        m_data_req;
  logic [31:0] m_data_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_wdata;
  logic        m_data_ack;
  logic [31:0] m_data_rdata;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        bus_err;
  logic        adel;
  logic        ades;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_rd;

  m_mem_ctrl #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .m_data_req(m_data_req), .m_data_addr(m_data_addr),
    .m_data_byteen(m_data_byteen), .m_data_wdata(m_data_wdata),
    .m_data_ack(m_data_ack), .m_data_rdata(m_data_rdata),
    .rd_data(rd_data), .rd_valid(rd_valid), .bus_err(bus_err),
    .adel(adel), .ades(ades)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int access_bytes(input logic [1:0] size);
    if (size == 2'd0) return 1;
    if (size == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic model_mis(input logic [1:0] size, input logic [31:0] addr);
    int nb;
    nb = access_bytes(size);
    return (int'(addr % 32'd4) % nb) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic we, input logic [1:0] size,
                                          input logic [31:0] addr);
    int nb;
    int off;
    if (!we) return 4'b0000;
    nb  = access_bytes(size);
    off = (int'(addr % 32'd4) / nb) * nb;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    int nb;
    nb = access_bytes(size);
    r  = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % nb) +: 8];
    return r;
  endfunction

  // Called shortly after a rising edge with the DUT idle; leaves it idle likewise.
  // delay = REQ cycles before ack (0 = ack on first REQ cycle); delay >= TO means no ack.
  task automatic do_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int delay, input logic [31:0] rdata);
    logic mis;
    logic exp_err;
    int   reqc;
    mis = model_mis(size, addr);
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    m_data_ack = 1'b0;
    @(negedge clk);
    chk1("adel", adel, mis & ~we);
    chk1("ades", ades, mis & we);
    chk1("stall_first", stall, ~mis);
    chk1("req_first", m_data_req, 1'b0);
    if (mis) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      #1;
      chk1("mis_no_req", m_data_req, 1'b0);
      chk1("mis_no_vld", rd_valid, 1'b0);
      return;
    end
    reqc = (delay < TO) ? delay + 1 : TO;
    for (int k = 0; k < reqc; k++) begin
      @(posedge clk); #1;
      m_data_ack   = (k == delay);
      m_data_rdata = (k == delay) ? rdata : $urandom;
      @(negedge clk);
      chk1("req_high", m_data_req, 1'b1);
      chk1("stall_req", stall, 1'b1);
      chk1("vld_in_req", rd_valid, 1'b0);
      chk32("addr", m_data_addr, {addr[31:2], 2'b00});
      chk32("byteen", 32'(m_data_byteen), 32'(model_be(we, size, addr)));
      if (we) chk32("wdata", m_data_wdata, model_wd(size, wdata));
    end
    @(posedge clk); #1;
    m_data_ack   = 1'b0;
    m_data_rdata = $urandom;
    exp_err = (delay >= TO);
    if (exp_err) last_rd = '0;
    else if (!we) last_rd = rdata;
    @(negedge clk);
    chk1("done_vld", rd_valid, 1'b1);
    chk1("done_err", bus_err, exp_err);
    chk32("done_rd", rd_data, last_rd);
    chk1("done_stall", stall, 1'b0);
    chk1("done_req", m_data_req, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    chk1("vld_pulse", rd_valid, 1'b0);
    chk1("err_pulse", bus_err, 1'b0);
    chk1("idle_req", m_data_req, 1'b0);
    chk1("idle_stall", stall, 1'b0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_addr = '0; req_wdata = '0; m_data_ack = 1'b0; m_data_rdata = '0;
    last_rd = '0;
    #1 reset = 1'b1;
    #2;
    chk1("rst_req", m_data_req, 1'b0);
    chk32("rst_addr", m_data_addr, 32'h0);
    chk32("rst_rd", rd_data, 32'h0);
    chk1("rst_vld", rd_valid, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;

    // Directed cases
    do_access(1'b0, 2'b10, 32'h0000_1004, 32'h0, 0, 32'hDEAD_BEEF);
    chk32("dir_load_rd", rd_data, 32'hDEAD_BEEF);
    do_access(1'b1, 2'b00, 32'h0000_2003, 32'h0000_00A5, 1, 32'h0);
    do_access(1'b1, 2'b01, 32'h0000_2002, 32'h0000_CAFE, 0, 32'h0);
    chk32("store_keeps_rd", rd_data, 32'hDEAD_BEEF);
    do_access(1'b0, 2'b01, 32'h0000_3001, 32'h0, 0, 32'h0);
    do_access(1'b1, 2'b10, 32'h0000_3002, 32'h1234_5678, 0, 32'h0);
    do_access(1'b0, 2'b11, 32'h0000_4008, 32'h0, 4, 32'h0BAD_F00D);
    do_access(1'b0, 2'b10, 32'h0000_5000, 32'h0, TO + 3, 32'h0);
    do_access(1'b0, 2'b10, 32'h0000_5004, 32'h0, TO - 1, 32'h5555_AAAA);
    do_access(1'b1, 2'b11, 32'h0000_6000, 32'hFEED_C0DE, TO - 1, 32'h0);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                $urandom_range(0, TO + 1), $urandom);
    end

    // Reset in the middle of REQ, then a stray ack
    do_access(1'b0, 2'b10, 32'h0000_7000, 32'h0, 0, 32'h1357_9BDF);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 32'h0000_8004; req_wdata = 32'hA5A5_0F0F;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk1("pre_rst_req", m_data_req, 1'b1);
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    last_rd = '0;
    chk1("arst_req", m_data_req, 1'b0);
    chk1("arst_stall", stall, 1'b0);
    chk32("arst_addr", m_data_addr, 32'h0);
    chk32("arst_be", 32'(m_data_byteen), 32'h0);
    chk32("arst_wd", m_data_wdata, 32'h0);
    chk32("arst_rd", rd_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_data_ack = 1'b1;
    m_data_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    m_data_ack = 1'b0;
    @(negedge clk);
    chk1("late_ack_vld", rd_valid, 1'b0);
    chk1("late_ack_req", m_data_req, 1'b0);
    @(posedge clk); #1;
    chk1("late_ack_vld2", rd_valid, 1'b0);
    chk32("late_ack_rd", rd_data, 32'h0);

    do_access(1'b1, 2'b00, 32'h0000_9001, 32'h0000_003C, 2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
